// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit holding the HI/LO pair for the E stage.
// A fixed-latency FSM; results are committed to HI/LO on the final busy edge.
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_start,
  input  logic [1:0]  E_md_op,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        E_mthi,
  input  logic        E_mtlo,
  input  logic        E_hilo_sel,
  input  logic        D_md_use,
  output logic [31:0] hilo_out,
  output logic        busy,
  output logic        md_stall
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [1:0]  op_r, op_s;
  logic [31:0] a_r, a_s, b_r, b_s;
  logic [31:0] hi_r, hi_s, lo_r, lo_s;

  logic signed [63:0] smul_s;
  logic [63:0] umul_s;
  logic [31:0] abs_a_s, abs_b_s, udivisor_s, sdivisor_s;
  logic [31:0] uq_s, ur_s, mq_s, mr_s, sq_s, sr_s;

  // Arithmetic on the latched operands; signed divide works on magnitudes so
  // 0x80000000 / -1 wraps cleanly and divide-by-zero never reaches the divider.
  always_comb begin
    smul_s     = $signed({{32{a_r[31]}}, a_r}) * $signed({{32{b_r[31]}}, b_r});
    umul_s     = {32'd0, a_r} * {32'd0, b_r};
    abs_a_s    = a_r[31] ? (32'd0 - a_r) : a_r;
    abs_b_s    = b_r[31] ? (32'd0 - b_r) : b_r;
    udivisor_s = (b_r == 32'd0) ? 32'd1 : b_r;
    sdivisor_s = (abs_b_s == 32'd0) ? 32'd1 : abs_b_s;
    uq_s       = a_r / udivisor_s;
    ur_s       = a_r % udivisor_s;
    mq_s       = abs_a_s / sdivisor_s;
    mr_s       = abs_a_s % sdivisor_s;
    sq_s       = (a_r[31] ^ b_r[31]) ? (32'd0 - mq_s) : mq_s;
    sr_s       = a_r[31] ? (32'd0 - mr_s) : mr_s;
  end

  // Next-state, operand capture, move handling and result commit.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    op_s    = op_r;
    a_s     = a_r;
    b_s     = b_r;
    hi_s    = hi_r;
    lo_s    = lo_r;
    case (state_r)
      IDLE: begin
        if (E_start) begin
          state_s = BUSY;
          op_s    = E_md_op;
          a_s     = E_A;
          b_s     = E_B;
          cnt_s   = E_md_op[1] ? DIV_CNT : MULT_CNT;
        end else begin
          if (E_mthi) hi_s = E_A;
          else        hi_s = hi_r;
          if (E_mtlo) lo_s = E_A;
          else        lo_s = lo_r;
        end
      end
      BUSY: begin
        if (cnt_r == 4'd1) begin
          state_s = IDLE;
          cnt_s   = 4'd0;
          case (op_r)
            2'b00: {hi_s, lo_s} = smul_s;
            2'b01: {hi_s, lo_s} = umul_s;
            2'b10: begin
              if (b_r != 32'd0) {hi_s, lo_s} = {sr_s, sq_s};
              else              {hi_s, lo_s} = {hi_r, lo_r};
            end
            2'b11: begin
              if (b_r != 32'd0) {hi_s, lo_s} = {ur_s, uq_s};
              else              {hi_s, lo_s} = {hi_r, lo_r};
            end
            default: {hi_s, lo_s} = {hi_r, lo_r};
          endcase
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      op_r    <= 2'd0;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      op_r    <= op_s;
      a_r     <= a_s;
      b_r     <= b_s;
      hi_r    <= hi_s;
      lo_r    <= lo_s;
    end
  end

  assign busy     = (state_r == BUSY);
  assign hilo_out = E_hilo_sel ? hi_r : lo_r;
  assign md_stall = D_md_use & (busy | E_start);

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected HI/LO pushed at issue, popped when busy drops.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        E_start;
  logic [1:0]  E_md_op;
  logic [31:0] E_A, E_B;
  logic        E_mthi, E_mtlo, E_hilo_sel, D_md_use;
  logic [31:0] hilo_out;
  logic        busy, md_stall;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];
  logic [31:0] model_hi, model_lo;

  mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .E_start(E_start), .E_md_op(E_md_op),
    .E_A(E_A), .E_B(E_B), .E_mthi(E_mthi), .E_mtlo(E_mtlo),
    .E_hilo_sel(E_hilo_sel), .D_md_use(D_md_use),
    .hilo_out(hilo_out), .busy(busy), .md_stall(md_stall)
  );

  always #5 clk = ~clk;

  // Reference model: returns {HI, LO} after the operation.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    logic signed [63:0] sa, sb, q, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      2'b00: model = sa * sb;
      2'b01: model = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) model = {hi, lo};
        else begin
          q = sa / sb;
          r = sa % sb;
          model = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) model = {hi, lo};
        else model = {a % b, a / b};
      end
    endcase
  endfunction

  // move_mode: 0 none, 1 mthi together with start, 2 mthi pulsed during busy
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit use_d, input int move_mode);
    logic [63:0] expv;
    logic [31:0] old_hi;
    int cycles, stalls, n;
    n = op[1] ? 10 : 5;
    old_hi = model_hi;
    @(negedge clk);
    E_start = 1'b1; E_md_op = op; E_A = a; E_B = b; D_md_use = use_d;
    E_mthi = (move_mode == 1);
    exp_q.push_back(model(op, a, b, model_hi, model_lo));
    {model_hi, model_lo} = model(op, a, b, model_hi, model_lo);
    stalls = 0;
    #1 if (md_stall) stalls++;
    @(negedge clk);
    E_start = 1'b0; E_mthi = 1'b0; E_A = $urandom; E_B = $urandom; E_hilo_sel = 1'b1;
    cycles = 0;
    while (busy && cycles < 40) begin
      cycles++;
      if (md_stall) stalls++;
      if (move_mode == 2 && cycles == 1) begin
        E_mthi = 1'b1; E_A = 32'hDEADBEEF;
      end else if (move_mode != 0 && cycles == 2) begin
        E_mthi = 1'b0;
        #1 vectors++;
        if (hilo_out !== old_hi) begin
          miscompares++;
          $display("FAIL move_ignored: HI got %h expected %h", hilo_out, old_hi);
        end
      end
      @(negedge clk);
    end
    vectors++;
    if (cycles !== n) begin
      miscompares++;
      $display("FAIL busy_len: got %0d cycles expected %0d", cycles, n);
    end
    vectors++;
    if (stalls !== (use_d ? n + 1 : 0)) begin
      miscompares++;
      $display("FAIL stall_len: got %0d expected %0d", stalls, use_d ? n + 1 : 0);
    end
    vectors++;
    if (md_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_release: got %b expected 0", md_stall);
    end
    D_md_use = 1'b0;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      expv = exp_q.pop_front();
      E_hilo_sel = 1'b1;
      #1 vectors++;
      if (hilo_out !== expv[63:32]) begin
        miscompares++;
        $display("FAIL hi_result op=%0d: got %h expected %h", op, hilo_out, expv[63:32]);
      end
      E_hilo_sel = 1'b0;
      #1 vectors++;
      if (hilo_out !== expv[31:0]) begin
        miscompares++;
        $display("FAIL lo_result op=%0d: got %h expected %h", op, hilo_out, expv[31:0]);
      end
    end
  endtask

  task automatic do_move(input bit to_hi, input bit to_lo, input logic [31:0] d);
    @(negedge clk);
    E_mthi = to_hi; E_mtlo = to_lo; E_A = d;
    if (to_hi) model_hi = d;
    if (to_lo) model_lo = d;
    @(negedge clk);
    E_mthi = 1'b0; E_mtlo = 1'b0;
    E_hilo_sel = 1'b1;
    #1 vectors++;
    if (hilo_out !== model_hi) begin
      miscompares++;
      $display("FAIL move_hi: got %h expected %h", hilo_out, model_hi);
    end
    E_hilo_sel = 1'b0;
    #1 vectors++;
    if (hilo_out !== model_lo) begin
      miscompares++;
      $display("FAIL move_lo: got %h expected %h", hilo_out, model_lo);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; E_start = 1'b0; E_md_op = 2'd0; E_A = 32'd0; E_B = 32'd0;
    E_mthi = 1'b0; E_mtlo = 1'b0; E_hilo_sel = 1'b1; D_md_use = 1'b1;
    repeat (3) @(negedge clk);
    model_hi = 32'd0; model_lo = 32'd0;
    vectors++;
    if (busy !== 1'b0 || md_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got busy=%b stall=%b expected 0/0", busy, md_stall);
    end
    vectors++;
    if (hilo_out !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_hi: got %h expected 0", hilo_out);
    end
    E_hilo_sel = 1'b0;
    #1 vectors++;
    if (hilo_out !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_lo: got %h expected 0", hilo_out);
    end
    reset = 1'b0; D_md_use = 1'b0;
  endtask

  task automatic test_mult();
    run_op(2'b00, 32'hFFFFFFFD, 32'd5, 1'b0, 0);
    run_op(2'b00, 32'h7FFFFFFF, 32'h80000000, 1'b0, 0);
    run_op(2'b01, 32'hFFFFFFFF, 32'd2, 1'b0, 0);
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
  endtask

  task automatic test_div();
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 0);
    run_op(2'b10, 32'd7, 32'hFFFFFFFE, 1'b0, 0);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 0);
    run_op(2'b11, 32'd7, 32'd2, 1'b0, 0);
    run_op(2'b11, 32'hFFFFFFF9, 32'd2, 1'b0, 0);
  endtask

  task automatic test_div_zero();
    do_move(1'b1, 1'b0, 32'h11);
    do_move(1'b0, 1'b1, 32'h22);
    run_op(2'b11, 32'd9, 32'd0, 1'b0, 0);
    run_op(2'b10, 32'hFFFFFFF0, 32'd0, 1'b0, 0);
    do_move(1'b1, 1'b1, 32'hCAFEF00D);
  endtask

  task automatic test_stall();
    run_op(2'b00, 32'd6, 32'd7, 1'b1, 2);
    run_op(2'b01, 32'd3, 32'd9, 1'b1, 1);
    run_op(2'b11, 32'd100, 32'd7, 1'b1, 0);
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    E_start = 1'b1; E_md_op = 2'b10; E_A = 32'd1000; E_B = 32'd7;
    @(negedge clk);
    E_start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_hi = 32'd0; model_lo = 32'd0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_busy: got %b expected 0", busy);
    end
    E_hilo_sel = 1'b1;
    #1 vectors++;
    if (hilo_out !== 32'd0) begin
      miscompares++;
      $display("FAIL abort_hi: got %h expected 0", hilo_out);
    end
    E_hilo_sel = 1'b0;
    #1 vectors++;
    if (hilo_out !== 32'd0) begin
      miscompares++;
      $display("FAIL abort_lo: got %h expected 0", hilo_out);
    end
    run_op(2'b00, 32'd12345, 32'hFFFFFF00, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      run_op(2'($urandom_range(0, 3)), $urandom,
             (i == 5) ? 32'd0 : 32'($urandom_range(0, 1000)) - 32'd500, 1'(i % 2), 0);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_stall();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
